// File: rtl/hamming_decode_engine_if.sv
// Byte-wide data-memory bus used by hamming_decode_engine.
//   mem_addr     engine -> memory  byte address
//   mem_rd_data  memory -> engine  combinational read data for mem_addr
//   mem_wr_en    engine -> memory  write strobe, memory writes on the rising clock edge
//   mem_wr_data  engine -> memory  write data
// master: engine side. slave: memory side.
interface hamming_decode_engine_if;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;

   modport master (
      output mem_addr,
      output mem_wr_en,
      output mem_wr_data,
      input  mem_rd_data
   );

   modport slave (
      input  mem_addr,
      input  mem_wr_en,
      input  mem_wr_data,
      output mem_rd_data
   );
endinterface

// File: rtl/hamming_decode_engine.sv
// SECDED decode engine for 16-bit Hamming codewords held in byte-wide memory.
// On an accepted start pulse it reads NUM_WORDS codewords (little-endian, two bytes each) from
// SRC_BASE, corrects single-bit errors and flags double-bit errors. It writes each result
// {dbl_flag, 4'b0, d[11:1]} to DST_BASE in the same layout, then raises halt.
// Ports:
//   CLK             rising-edge clock
//   reset_n         asynchronous active-low reset
//   start           one-cycle run request, honoured only in IDLE/DONE
//   halt            run complete, held until the next accepted start
//   mem             memory bus (hamming_decode_engine_if.master)
//   err_single_cnt  single-error count of the last run
//   err_double_cnt  double-error count of the last run
// Build option: define HAMMING_STATS_EN to enable the saturating error counters; otherwise
// both count outputs are tied to zero and no counter flops are built.
module hamming_decode_engine #(
   parameter int unsigned SRC_BASE  = 64,
   parameter int unsigned DST_BASE  = 94,
   parameter int unsigned NUM_WORDS = 15
) (
   input  logic                           CLK,
   input  logic                           reset_n,
   input  logic                           start,
   output logic                           halt,
   hamming_decode_engine_if.master        mem,
   output logic [7:0]                     err_single_cnt,
   output logic [7:0]                     err_double_cnt
);

   typedef enum logic [2:0] {
      StIdle,
      StRdLo,
      StRdHi,
      StWrLo,
      StWrHi,
      StDone
   } state_e;

   localparam logic [7:0] SrcBase = SRC_BASE[7:0];
   localparam logic [7:0] DstBase = DST_BASE[7:0];
   localparam logic [5:0] LastIdx = 6'(NUM_WORDS - 1);

   state_e      state_q, state_d;
   logic [5:0]  idx_q;
   logic [7:0]  lo_q, hi_q;
   logic        halt_q;
   logic        accept;

   logic [15:0] cw;
   logic [3:0]  syndrome;
   logic        parity;
   logic        err_double;
   logic [15:0] fixed;
   logic [15:0] result;
   logic [7:0]  word_off;

   assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
   assign word_off = {1'b0, idx_q, 1'b0};

   // ---------------------------------------------------------------------------------------
   // Decoder: works on the captured codeword, stable through both write cycles.
   // ---------------------------------------------------------------------------------------
   assign cw = {hi_q, lo_q};

   always_comb begin
      syndrome = 4'd0;
      for (int k = 1; k < 16; k++) begin
         if (cw[k]) syndrome = syndrome ^ 4'(k);
      end
   end

   assign parity     = ^cw;
   assign err_double = !parity && (syndrome != 4'd0);

   always_comb begin
      fixed = cw;
      // syndrome 0 with odd parity means p16 itself flipped: data is untouched
      if (parity && (syndrome != 4'd0)) fixed[syndrome] = ~cw[syndrome];
   end

   assign result = {err_double, 4'b0000, fixed[15:9], fixed[7:5], fixed[3]};

   // ---------------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= 6'd0;
         lo_q    <= 8'd0;
         hi_q    <= 8'd0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            idx_q <= 6'd0;
         end else if ((state_q == StWrHi) && (idx_q != LastIdx)) begin
            idx_q <= idx_q + 6'd1;
         end
         if (state_q == StRdLo) lo_q <= mem.mem_rd_data;
         if (state_q == StRdHi) hi_q <= mem.mem_rd_data;
         if (accept) begin
            halt_q <= 1'b0;
         end else if (state_q == StDone) begin
            halt_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRdLo;
         StRdLo:  state_d = StRdHi;
         StRdHi:  state_d = StWrLo;
         StWrLo:  state_d = StWrHi;
         StWrHi:  state_d = (idx_q == LastIdx) ? StDone : StRdLo;
         StDone:  if (start) state_d = StRdLo;
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // FSM: outputs (address arithmetic wraps at 8 bits)
   // ---------------------------------------------------------------------------------------
   always_comb begin
      mem.mem_addr    = 8'd0;
      mem.mem_wr_en   = 1'b0;
      mem.mem_wr_data = 8'd0;
      unique case (state_q)
         StRdLo: mem.mem_addr = SrcBase + word_off;
         StRdHi: mem.mem_addr = SrcBase + word_off + 8'd1;
         StWrLo: begin
            mem.mem_addr    = DstBase + word_off;
            mem.mem_wr_en   = 1'b1;
            mem.mem_wr_data = result[7:0];
         end
         StWrHi: begin
            mem.mem_addr    = DstBase + word_off + 8'd1;
            mem.mem_wr_en   = 1'b1;
            mem.mem_wr_data = result[15:8];
         end
         default: ;
      endcase
   end

   assign halt = halt_q;

   // ---------------------------------------------------------------------------------------
   // Error statistics
   // ---------------------------------------------------------------------------------------
`ifdef HAMMING_STATS_EN
   logic [7:0] single_cnt_q, double_cnt_q;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         single_cnt_q <= 8'd0;
         double_cnt_q <= 8'd0;
      end else if (accept) begin
         single_cnt_q <= 8'd0;
         double_cnt_q <= 8'd0;
      end else if (state_q == StWrHi) begin
         if (parity && (single_cnt_q != 8'hFF)) single_cnt_q <= single_cnt_q + 8'd1;
         if (err_double && (double_cnt_q != 8'hFF)) double_cnt_q <= double_cnt_q + 8'd1;
      end
   end

   assign err_single_cnt = single_cnt_q;
   assign err_double_cnt = double_cnt_q;
`else
   assign err_single_cnt = 8'd0;
   assign err_double_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_hamming_decode_engine.sv
// Self-checking bench for hamming_decode_engine (default parameters: 15 words, 64 -> 94).
module tb_hamming_decode_engine;

   localparam int unsigned Src = 64;
   localparam int unsigned Dst = 94;
   localparam int unsigned Nw  = 15;
   localparam int          HaltEdges = 4 * Nw + 1;
`ifdef HAMMING_STATS_EN
   localparam bit Stats = 1'b1;
`else
   localparam bit Stats = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       halt;
   logic [7:0] err_single_cnt;
   logic [7:0] err_double_cnt;
   logic [7:0] ram [256];

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q [$];  // {addr, byte} in write order
   logic [15:0] exp_w;

   hamming_decode_engine_if mem_bus ();

   hamming_decode_engine dut (
      .CLK            (CLK),
      .reset_n        (reset_n),
      .start          (start),
      .halt           (halt),
      .mem            (mem_bus.master),
      .err_single_cnt (err_single_cnt),
      .err_double_cnt (err_double_cnt)
   );

   always #5 CLK = ~CLK;

   assign mem_bus.mem_rd_data = ram[mem_bus.mem_addr];

   always @(posedge CLK) begin
      if (mem_bus.mem_wr_en) ram[mem_bus.mem_addr] <= mem_bus.mem_wr_data;
   end

   // Scoreboard: every write strobe must match the next expected {addr, byte}.
   always @(negedge CLK) begin
      if (reset_n && mem_bus.mem_wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr=%0d data=%02h, required no write",
                     mem_bus.mem_addr, mem_bus.mem_wr_data);
         end else begin
            exp_w = exp_q.pop_front();
            if ({mem_bus.mem_addr, mem_bus.mem_wr_data} !== exp_w) begin
               errors++;
               $display("FAIL write_data: got addr=%0d data=%02h, required addr=%0d data=%02h",
                        mem_bus.mem_addr, mem_bus.mem_wr_data, exp_w[15:8], exp_w[7:0]);
            end
         end
      end
   end

   // Reference encoder, built from the bit layout rather than from a syndrome decoder.
   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] c;
      c       = 16'd0;
      c[3]    = d[0];
      c[7:5]  = d[3:1];
      c[15:9] = d[10:4];
      for (int j = 1; j <= 8; j = j * 2) begin
         for (int k = 3; k < 16; k++) begin
            if (k != 4 && k != 8 && ((k & j) != 0)) c[j] = c[j] ^ c[k];
         end
      end
      c[0] = ^c[15:1];
      return c;
   endfunction

   function automatic logic [10:0] extract(input logic [15:0] c);
      return {c[15:9], c[7:5], c[3]};
   endfunction

   task automatic load_word(input int i, input logic [15:0] cw);
      ram[8'(Src + 2 * i)]     = cw[7:0];
      ram[8'(Src + 2 * i + 1)] = cw[15:8];
   endtask

   task automatic push_expect(input int i, input logic [15:0] res);
      exp_q.push_back({8'(Dst + 2 * i), res[7:0]});
      exp_q.push_back({8'(Dst + 2 * i + 1), res[15:8]});
   endtask

   // Pulses start, then counts edges after the sampling edge until halt. Optionally pulses a
   // stray start or asserts reset after a given edge. edges = -1 on timeout.
   task automatic start_run(input int stray_at, input int reset_at, output int edges,
                            output logic halt_s, output logic [7:0] single_s,
                            output logic [7:0] double_s);
      @(posedge CLK);
      #1 start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      halt_s   = halt;
      single_s = err_single_cnt;
      double_s = err_double_cnt;
      edges    = -1;
      for (int n = 1; n <= 300; n++) begin
         @(posedge CLK);
         #1 start = (n == stray_at);
         if (n == reset_at) begin
            reset_n = 1'b0;
            edges   = n;
            return;
         end
         if (halt) begin
            edges = n;
            return;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if (halt !== 1'b0) begin
         errors++; $display("FAIL reset_halt: got %b, required 0", halt);
      end
      checks++;
      if (mem_bus.mem_wr_en !== 1'b0) begin
         errors++; $display("FAIL reset_wr_en: got %b, required 0", mem_bus.mem_wr_en);
      end
      checks++;
      if (mem_bus.mem_addr !== 8'd0) begin
         errors++; $display("FAIL reset_addr: got %0d, required 0", mem_bus.mem_addr);
      end
      checks++;
      if (mem_bus.mem_wr_data !== 8'd0) begin
         errors++; $display("FAIL reset_wr_data: got %02h, required 00", mem_bus.mem_wr_data);
      end
      checks++;
      if ({err_single_cnt, err_double_cnt} !== 16'd0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d, required 0/0",
                  err_single_cnt, err_double_cnt);
      end
      @(posedge CLK);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (halt !== 1'b0 || mem_bus.mem_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got halt=%b wr_en=%b, required 0/0",
                  halt, mem_bus.mem_wr_en);
      end
   endtask

   task automatic test_directed();
      int edges;
      logic h;
      logic [7:0] s1, s2;
      logic [10:0] d;
      load_word(0, 16'h0000); push_expect(0, 16'h0000);
      load_word(1, 16'hFFDF); push_expect(1, 16'h07FF);  // bit 5 flipped
      load_word(2, 16'hFFFE); push_expect(2, 16'h07FF);  // p16 flipped
      load_word(3, 16'hFDDF); push_expect(3, 16'h87ED);  // bits 5 and 9 flipped
      for (int i = 4; i < Nw; i++) begin
         d = 11'(i * 137 + 5);
         load_word(i, encode(d));
         push_expect(i, {5'b0, d});
      end
      start_run(0, 0, edges, h, s1, s2);
      checks++;
      if (edges !== HaltEdges) begin
         errors++; $display("FAIL directed_halt_edges: got %0d, required %0d", edges, HaltEdges);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL directed_writes_left: got %0d, required 0", exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (err_single_cnt !== (Stats ? 8'd2 : 8'd0)) begin
         errors++; $display("FAIL directed_single_cnt: got %0d, required %0d",
                            err_single_cnt, Stats ? 2 : 0);
      end
      checks++;
      if (err_double_cnt !== (Stats ? 8'd1 : 8'd0)) begin
         errors++; $display("FAIL directed_double_cnt: got %0d, required %0d",
                            err_double_cnt, Stats ? 1 : 0);
      end
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (halt !== 1'b1 || mem_bus.mem_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL done_hold: got halt=%b wr_en=%b, required 1/0", halt, mem_bus.mem_wr_en);
      end
   endtask

   // Random 1-2 bit errors; restarts from DONE and throws a stray start into RD_HI of word 3.
   task automatic test_random_restart();
      int edges, exp_single, exp_double, nflip, a, b;
      logic h;
      logic [7:0] s1, s2;
      logic [10:0] d;
      logic [15:0] cw;
      exp_single = 0;
      exp_double = 0;
      for (int i = 0; i < Nw; i++) begin
         d     = 11'($urandom_range(0, 2047));
         cw    = encode(d);
         nflip = $urandom_range(1, 2);
         a     = $urandom_range(0, 15);
         b     = (a + $urandom_range(1, 15)) % 16;
         cw[a] = ~cw[a];
         if (nflip == 2) begin
            cw[b] = ~cw[b];
            exp_double++;
            push_expect(i, {1'b1, 4'b0, extract(cw)});
         end else begin
            exp_single++;
            push_expect(i, {5'b0, d});
         end
         load_word(i, cw);
      end
      start_run(13, 0, edges, h, s1, s2);
      checks++;
      if (h !== 1'b0) begin
         errors++; $display("FAIL restart_halt_fall: got %b, required 0", h);
      end
      checks++;
      if ({s1, s2} !== 16'd0) begin
         errors++; $display("FAIL restart_counters_clear: got %0d/%0d, required 0/0", s1, s2);
      end
      checks++;
      if (edges !== HaltEdges) begin
         errors++; $display("FAIL random_halt_edges: got %0d, required %0d", edges, HaltEdges);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL random_writes_left: got %0d, required 0", exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (err_single_cnt !== (Stats ? 8'(exp_single) : 8'd0)) begin
         errors++; $display("FAIL random_single_cnt: got %0d, required %0d",
                            err_single_cnt, Stats ? exp_single : 0);
      end
      checks++;
      if (err_double_cnt !== (Stats ? 8'(exp_double) : 8'd0)) begin
         errors++; $display("FAIL random_double_cnt: got %0d, required %0d",
                            err_double_cnt, Stats ? exp_double : 0);
      end
   endtask

   task automatic test_reset_midrun();
      int edges, untouched;
      logic h;
      logic [7:0] s1, s2;
      logic [10:0] d;
      logic [15:0] cw;
      for (int i = 0; i < 2 * Nw; i++) ram[8'(Dst + i)] = 8'h78;  // never a valid result hi byte
      for (int i = 0; i < Nw; i++) begin
         d  = 11'($urandom_range(0, 2047));
         cw = encode(d);
         cw[i] = ~cw[i];
         load_word(i, cw);
         if (i < 7) push_expect(i, {5'b0, d});
      end
      start_run(0, 29, edges, h, s1, s2);  // edge 29 leaves word 7 in RD_HI
      #1;
      checks++;
      if (edges !== 29) begin
         errors++; $display("FAIL midrun_reached: got %0d, required 29", edges);
      end
      checks++;
      if (halt !== 1'b0 || mem_bus.mem_wr_en !== 1'b0 || mem_bus.mem_addr !== 8'd0) begin
         errors++;
         $display("FAIL midrun_reset_state: got halt=%b wr_en=%b addr=%0d, required 0/0/0",
                  halt, mem_bus.mem_wr_en, mem_bus.mem_addr);
      end
      checks++;
      if ({err_single_cnt, err_double_cnt} !== 16'd0) begin
         errors++; $display("FAIL midrun_counters: got %0d/%0d, required 0/0",
                            err_single_cnt, err_double_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL midrun_words_written: got %0d bytes missing, required 0",
                            exp_q.size());
         exp_q.delete();
      end
      untouched = 0;
      for (int i = 7; i < Nw; i++) if (ram[8'(Dst + 2 * i + 1)] === 8'h78) untouched++;
      checks++;
      if (untouched != Nw - 7) begin
         errors++; $display("FAIL midrun_untouched: got %0d words, required %0d",
                            untouched, Nw - 7);
      end
      @(negedge CLK);
      reset_n = 1'b1;
      // A full run from IDLE after the abort.
      for (int i = 0; i < Nw; i++) begin
         d = 11'(2047 - i * 91);
         load_word(i, encode(d));
         push_expect(i, {5'b0, d});
      end
      start_run(0, 0, edges, h, s1, s2);
      checks++;
      if (edges !== HaltEdges) begin
         errors++; $display("FAIL post_reset_halt_edges: got %0d, required %0d",
                            edges, HaltEdges);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL post_reset_writes_left: got %0d, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      repeat (3) @(posedge CLK);
      #1;
      test_reset();
      test_directed();
      test_random_restart();
      test_reset_midrun();
      repeat (2) @(posedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
